host_bus_bridge: RTL and testbench

Bridges the asynchronous 573 host CPU bus (chip select, read/write strobes, address, 16-bit data) into the FPGA system clock domain and converts each host access into a single-cycle request/acknowledge transaction on the internal register bus. It sits directly upstream of the bidirectional data-pin buffers. `host_data_out` feeds the buffer data input, `host_data_oe` feeds its active-high enable, and `host_data_in` is taken from the buffer's input path.

---
 rtl/host_bus_pkg.sv | 19 +
 rtl/host_bus_sync.sv | 23 ++
 rtl/host_bus_bridge.sv | 171 +++++++++++++++++
 tb/tb_host_bus_bridge.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/host_bus_pkg.sv
// Shared types and constants for the host CPU bus bridge.
package host_bus_pkg;

    localparam int HOST_BUS_ADDR_WIDTH  = 4;
    localparam int HOST_BUS_DATA_WIDTH  = 16;
    localparam int HOST_BUS_SYNC_STAGES = 2;

    // Wide enough for any practical data width; users slice the low bits.
    localparam logic [63:0] HOST_BUS_ALL_ONES = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_HOLD,
        ST_WR_HOLD,
        ST_WR_WAIT
    } bus_state_t;

endpackage

// File: rtl/host_bus_sync.sv
// N-stage synchronizer for an active-low asynchronous strobe; resets to the inactive level (1).
module host_bus_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_p;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p <= '1;
        end else begin
            sync_p <= {sync_p[STAGES-2:0], d};
        end
    end

    assign q = sync_p[STAGES-1];

endmodule

// File: rtl/host_bus_bridge.sv
// Asynchronous host CPU bus to internal req/ack register bus bridge.
// Optional wait-state timeout is built only when HOST_BUS_TIMEOUT_EN is defined.
module host_bus_bridge
    import host_bus_pkg::*;
#(
    parameter int ADDR_WIDTH     = HOST_BUS_ADDR_WIDTH,
    parameter int DATA_WIDTH     = HOST_BUS_DATA_WIDTH,
    parameter int SYNC_STAGES    = HOST_BUS_SYNC_STAGES,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  host_cs_n,
    input  logic                  host_rd_n,
    input  logic                  host_wr_n,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_data_in,
    output logic [DATA_WIDTH-1:0] host_data_out,
    output logic                  host_data_oe,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wdata,
    output logic                  reg_write,
    output logic                  reg_read,
    input  logic [DATA_WIDTH-1:0] reg_rdata,
    input  logic                  reg_ack,
    output logic                  timeout_flag
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("host_bus_bridge: SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("host_bus_bridge: TIMEOUT_CYCLES must be at least 1");
    end

    logic cs_n_s, rd_n_s, wr_n_s, rd_n_d;

    host_bus_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (.clk(clk), .reset(reset), .d(host_cs_n), .q(cs_n_s));
    host_bus_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (.clk(clk), .reset(reset), .d(host_rd_n), .q(rd_n_s));
    host_bus_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (.clk(clk), .reset(reset), .d(host_wr_n), .q(wr_n_s));

    bus_state_t            state, state_nxt;
    logic [ADDR_WIDTH-1:0] reg_addr_nxt;
    logic [DATA_WIDTH-1:0] reg_wdata_nxt, data_out_nxt, rd_result;
    logic                  data_oe_nxt, reg_write_nxt, reg_read_nxt;
    logic                  rd_fall, both_low, ack_ok, timeout_hit;

    assign rd_fall  = rd_n_d & ~rd_n_s;
    assign both_low = ~rd_n_s & ~wr_n_s;
    // An ack coinciding with our own request pulse belongs to nothing we issued.
    assign ack_ok   = reg_ack & ~reg_read & ~reg_write;
    assign rd_result = ack_ok ? reg_rdata : HOST_BUS_ALL_ONES[DATA_WIDTH-1:0];

`ifdef HOST_BUS_TIMEOUT_EN
    localparam int TO_RAW_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TO_W     = (TO_RAW_W < 8) ? 8 : ((TO_RAW_W > 16) ? 16 : TO_RAW_W);

    logic [TO_W-1:0] to_cnt;
    logic            in_wait, timeout_flag_r;

    assign in_wait     = (state == ST_RD_WAIT) || (state == ST_WR_WAIT);
    assign timeout_hit = in_wait && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || (state_nxt != state)) begin
            to_cnt <= '0;
        end else if (in_wait) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_flag_r <= 1'b0;
        end else if (timeout_hit && !ack_ok) begin
            timeout_flag_r <= 1'b1;
        end
    end

    assign timeout_flag = timeout_flag_r;
`else
    assign timeout_hit  = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        reg_addr_nxt  = reg_addr;
        reg_wdata_nxt = reg_wdata;
        data_out_nxt  = host_data_out;
        data_oe_nxt   = host_data_oe;
        reg_read_nxt  = 1'b0;
        reg_write_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!cs_n_s && !both_low) begin
                    if (rd_fall) begin
                        reg_addr_nxt = host_addr;
                        reg_read_nxt = 1'b1;
                        data_oe_nxt  = 1'b1;
                        state_nxt    = ST_RD_WAIT;
                    end else if (!wr_n_s) begin
                        state_nxt = ST_WR_HOLD;
                    end
                end
            end
            ST_WR_HOLD: begin
                if (!wr_n_s) begin
                    reg_addr_nxt  = host_addr;
                    reg_wdata_nxt = host_data_in;
                end else begin
                    reg_write_nxt = 1'b1;
                    state_nxt     = ST_WR_WAIT;
                end
            end
            ST_WR_WAIT: begin
                if (ack_ok || timeout_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RD_WAIT: begin
                if (rd_n_s) begin
                    data_oe_nxt = 1'b0;
                end
                // A dropped output enable marks a read the host already gave up on.
                if (ack_ok || timeout_hit) begin
                    if (!host_data_oe || rd_n_s) begin
                        data_oe_nxt = 1'b0;
                        state_nxt   = ST_IDLE;
                    end else begin
                        data_out_nxt = rd_result;
                        state_nxt    = ST_RD_HOLD;
                    end
                end
            end
            ST_RD_HOLD: begin
                if (rd_n_s) begin
                    data_oe_nxt = 1'b0;
                    state_nxt   = ST_IDLE;
                end
            end
            default: begin
                data_oe_nxt = 1'b0;
                state_nxt   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            rd_n_d        <= 1'b1;
            reg_addr      <= '0;
            reg_wdata     <= '0;
            host_data_out <= '0;
            host_data_oe  <= 1'b0;
            reg_read      <= 1'b0;
            reg_write     <= 1'b0;
        end else begin
            state         <= state_nxt;
            rd_n_d        <= rd_n_s;
            reg_addr      <= reg_addr_nxt;
            reg_wdata     <= reg_wdata_nxt;
            host_data_out <= data_out_nxt;
            host_data_oe  <= data_oe_nxt;
            reg_read      <= reg_read_nxt;
            reg_write     <= reg_write_nxt;
        end
    end

endmodule

// File: tb/tb_host_bus_bridge.sv
// Directed, table-driven bench for host_bus_bridge.
module tb_host_bus_bridge;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int SS = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          host_cs_n, host_rd_n, host_wr_n;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_data_in;
    logic [DW-1:0] host_data_out;
    logic          host_data_oe;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic          reg_write, reg_read;
    logic [DW-1:0] reg_rdata;
    logic          reg_ack;
    logic          timeout_flag;

    always #5 clk = ~clk;

    host_bus_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .host_cs_n(host_cs_n), .host_rd_n(host_rd_n), .host_wr_n(host_wr_n),
        .host_addr(host_addr), .host_data_in(host_data_in),
        .host_data_out(host_data_out), .host_data_oe(host_data_oe),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_write(reg_write), .reg_read(reg_read),
        .reg_rdata(reg_rdata), .reg_ack(reg_ack),
        .timeout_flag(timeout_flag)
    );

    int chk_cnt   = 0;
    int pass_cnt  = 0;
    int rd_pulses = 0;
    int wr_pulses = 0;

    // Pulse counters sample well after the edge so every request cycle is seen once.
    always @(posedge clk) begin
        #2;
        if (reg_read === 1'b1)  rd_pulses++;
        if (reg_write === 1'b1) wr_pulses++;
    end

    typedef struct {
        bit          is_wr;
        logic [3:0]  addr;
        logic [15:0] data;
        int          ack_dly;
        logic [3:0]  exp_addr;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic wait_pulse(input bit wr, output int n);
        n = 0;
        while (((wr ? reg_write : reg_read) !== 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic slave_ack(input int dly, input logic [15:0] d);
        repeat (dly) @(negedge clk);
        reg_ack   = 1'b1;
        reg_rdata = d;
        @(negedge clk);
        reg_ack   = 1'b0;
        reg_rdata = 16'h0000;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [15:0] d, input int dly,
                            input logic [3:0] ea, input logic [15:0] ed);
        int n, r0, w0;
        r0 = rd_pulses;
        w0 = wr_pulses;
        host_cs_n    = 1'b0;
        host_addr    = a;
        host_data_in = d;
        host_wr_n    = 1'b0;
        repeat (10) @(negedge clk);
        host_wr_n = 1'b1;
        wait_pulse(1'b1, n);
        check("wr_latency", n, SS + 1);
        check("wr_addr", reg_addr, ea);
        check("wr_wdata", reg_wdata, ed);
        slave_ack(dly, 16'h0000);
        host_cs_n = 1'b1;
        repeat (3) @(negedge clk);
        check("wr_pulse_count", wr_pulses - w0, 1);
        check("wr_no_read", rd_pulses - r0, 0);
        check("wr_oe_low", host_data_oe, 1'b0);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [15:0] rdata, input int dly,
                           input logic [3:0] ea, input logic [15:0] ed);
        int n, r0, w0;
        r0 = rd_pulses;
        w0 = wr_pulses;
        host_cs_n = 1'b0;
        host_addr = a;
        host_rd_n = 1'b0;
        wait_pulse(1'b0, n);
        check("rd_latency", n, SS + 1);
        check("rd_addr", reg_addr, ea);
        check("rd_oe_at_request", host_data_oe, 1'b1);
        slave_ack(dly, rdata);
        check("rd_dout", host_data_out, ed);
        check("rd_oe_hold", host_data_oe, 1'b1);
        repeat (3) @(negedge clk);
        check("rd_oe_still_held", host_data_oe, 1'b1);
        host_rd_n = 1'b1;
        host_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rd_oe_before_release", host_data_oe, 1'b1);
        @(negedge clk);
        check("rd_oe_released", host_data_oe, 1'b0);
        check("rd_dout_retained", host_data_out, ed);
        check("rd_pulse_count", rd_pulses - r0, 1);
        check("rd_no_write", wr_pulses - w0, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, r0, w0;

        vecs[0] = '{1'b1, 4'h3, 16'hA5C3, 2, 4'h3, 16'hA5C3};
        vecs[1] = '{1'b0, 4'h7, 16'h1234, 3, 4'h7, 16'h1234};
        vecs[2] = '{1'b1, 4'hF, 16'hFFFF, 1, 4'hF, 16'hFFFF};
        vecs[3] = '{1'b0, 4'h0, 16'h8001, 1, 4'h0, 16'h8001};
        vecs[4] = '{1'b1, 4'h0, 16'h0000, 5, 4'h0, 16'h0000};
        vecs[5] = '{1'b0, 4'hA, 16'h5A5A, 2, 4'hA, 16'h5A5A};

        reset        = 1'b1;
        host_cs_n    = 1'b1;
        host_rd_n    = 1'b1;
        host_wr_n    = 1'b1;
        host_addr    = '0;
        host_data_in = '0;
        reg_rdata    = '0;
        reg_ack      = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data_out", host_data_out, 16'h0000);
        check("rst_data_oe", host_data_oe, 1'b0);
        check("rst_reg_addr", reg_addr, 4'h0);
        check("rst_reg_wdata", reg_wdata, 16'h0000);
        check("rst_reg_write", reg_write, 1'b0);
        check("rst_reg_read", reg_read, 1'b0);
        check("rst_timeout_flag", timeout_flag, 1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].addr, vecs[i].data, vecs[i].ack_dly, vecs[i].exp_addr, vecs[i].exp_data);
            else
                do_read(vecs[i].addr, vecs[i].data, vecs[i].ack_dly, vecs[i].exp_addr, vecs[i].exp_data);
            repeat (2) @(negedge clk);
        end

        // Stray ack while idle must not disturb anything.
        r0 = rd_pulses;
        w0 = wr_pulses;
        reg_ack   = 1'b1;
        reg_rdata = 16'hDEAD;
        @(negedge clk);
        reg_ack   = 1'b0;
        reg_rdata = 16'h0000;
        repeat (2) @(negedge clk);
        check("stray_ack_dout", host_data_out, 16'h5A5A);
        check("stray_ack_oe", host_data_oe, 1'b0);
        check("stray_ack_pulses", (rd_pulses - r0) + (wr_pulses - w0), 0);

        // Read and write strobes low together: invalid, nothing issued.
        r0 = rd_pulses;
        w0 = wr_pulses;
        host_cs_n = 1'b0;
        host_addr = 4'h1;
        host_rd_n = 1'b0;
        host_wr_n = 1'b0;
        repeat (10) @(negedge clk);
        check("invalid_oe", host_data_oe, 1'b0);
        check("invalid_no_read", rd_pulses - r0, 0);
        host_cs_n = 1'b1;
        host_rd_n = 1'b1;
        host_wr_n = 1'b1;
        repeat (6) @(negedge clk);
        check("invalid_no_read_after", rd_pulses - r0, 0);
        check("invalid_no_write_after", wr_pulses - w0, 0);

        // Host abandons the read before the slave answers; late data is dropped.
        r0 = rd_pulses;
        host_cs_n = 1'b0;
        host_addr = 4'h2;
        host_rd_n = 1'b0;
        wait_pulse(1'b0, n);
        check("abort_rd_latency", n, SS + 1);
        @(negedge clk);
        host_rd_n = 1'b1;
        host_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_oe_dropped", host_data_oe, 1'b0);
        slave_ack(1, 16'hBEEF);
        @(negedge clk);
        check("abort_dout_unchanged", host_data_out, 16'h5A5A);
        check("abort_oe_low", host_data_oe, 1'b0);
        check("abort_one_read", rd_pulses - r0, 1);
        do_read(4'h9, 16'h0C0F, 1, 4'h9, 16'h0C0F);

        // Reset in the middle of a write hold aborts the write.
        w0 = wr_pulses;
        host_cs_n    = 1'b0;
        host_addr    = 4'h5;
        host_data_in = 16'h1111;
        host_wr_n    = 1'b0;
        repeat (6) @(negedge clk);
        check("hold_captured_addr", reg_addr, 4'h5);
        check("hold_captured_data", reg_wdata, 16'h1111);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_reg_addr", reg_addr, 4'h0);
        check("midrst_reg_wdata", reg_wdata, 16'h0000);
        check("midrst_data_out", host_data_out, 16'h0000);
        check("midrst_data_oe", host_data_oe, 1'b0);
        check("midrst_reg_write", reg_write, 1'b0);
        check("midrst_reg_read", reg_read, 1'b0);
        host_wr_n = 1'b1;
        host_cs_n = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_no_write", wr_pulses - w0, 0);
        do_write(4'h6, 16'h0F0F, 2, 4'h6, 16'h0F0F);

        // Read with a silent slave.
        host_cs_n = 1'b0;
        host_addr = 4'h4;
        host_rd_n = 1'b0;
        wait_pulse(1'b0, n);
        check("noack_rd_latency", n, SS + 1);
`ifdef HOST_BUS_TIMEOUT_EN
        repeat (TO - 1) @(negedge clk);
        check("to_not_yet_dout", host_data_out, 16'h0000);
        check("to_not_yet_flag", timeout_flag, 1'b0);
        @(negedge clk);
        check("to_dout_all_ones", host_data_out, 16'hFFFF);
        check("to_flag_set", timeout_flag, 1'b1);
        host_rd_n = 1'b1;
        host_cs_n = 1'b1;
        repeat (6) @(negedge clk);
        check("to_flag_sticky", timeout_flag, 1'b1);
        check("to_oe_released", host_data_oe, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("to_flag_cleared", timeout_flag, 1'b0);
        reset = 1'b0;
`else
        repeat (40) @(negedge clk);
        check("noto_flag_zero", timeout_flag, 1'b0);
        check("noto_dout_unchanged", host_data_out, 16'h0000);
        check("noto_still_waiting_oe", host_data_oe, 1'b1);
        host_rd_n = 1'b1;
        host_cs_n = 1'b1;
        repeat (4) @(negedge clk);
        check("noto_oe_released", host_data_oe, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
